hamming_decoder_8bit_stream: RTL
================================

# hamming_decoder_8bit_stream

Streaming two-stage pipelined Hamming (12,8) decoder with single-error correction. Sits on the receive side of the 12-bit protected data path and accepts codewords with a valid/ready handshake. It returns the corrected 8-bit data, per-word error flags and the raw syndrome. Saturating counters record corrected and uncorrectable words.

## Interface
- CNT_W, default 16: width of each error counter.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  code_in is valid this cycle.
- in_ready  output  1  decoder accepts code_in this cycle.
- code_in  input  12  codeword: [11:4] = data d7..d0, [3:0] = parity p3..p0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- data_out  output  8  corrected data.
- err_corr  output  1  single-bit error corrected; the bit is data or parity.
- err_unc  output  1  uncorrectable syndrome; data_out is the raw data field.
- syndrome  output  4  syndrome {s3,s2,s1,s0} of this word.
- cnt_clr  input  1  synchronously clears both counters.
- corr_cnt  output  CNT_W  count of delivered words with err_corr=1.
- unc_cnt  output  CNT_W  count of delivered words with err_unc=1.

## Operation
- Parity equations:
  - p0 = d0^d1^d3^d4^d6
  - p1 = d0^d2^d3^d5^d6
  - p2 = d1^d2^d3^d7
  - p3 = d4^d5^d6^d7
  - s[i] = received p[i] ^ recomputed p[i].
- Syndrome decode:
  - 0: no error.
  - 1, 2, 4, 8: error in parity bit p0, p1, p2, p3. Set err_corr; data passes unchanged.
  - 3, 5, 6, 7, 9, 10, 11, 12: flip d0, d1, d2, d3, d4, d5, d6, d7 respectively. Set err_corr.
  - 13, 14, 15: set err_unc; data passes unchanged.
- err_corr and err_unc are never both 1.
- Double errors whose syndrome is a legal single-error value are miscorrected. This is inherent to SEC-only (12,8) and is not flagged.
- Stage 1 registers code_in and the computed syndrome. Stage 2 registers the corrected data, the flags and the syndrome.
- Counters:
  - Increment on the output handshake (out_valid & out_ready) when the matching flag is set.
  - Saturate at 2^CNT_W-1.
  - When cnt_clr and an increment occur in the same cycle, clear wins and the counter goes to 0.

## Timing
- Latency: a word accepted in cycle N appears on the outputs in cycle N+2 when there is no backpressure. Throughput is 1 word/cycle.
- Pipeline control:
  - adv2 = ~s2_valid | out_ready
  - adv1 = ~s1_valid | adv2
  - in_ready = adv1 (combinational from out_ready).
- Transfer happens only when valid & ready are both high.
- While out_valid=1 and out_ready=0: data_out, err_corr, err_unc and syndrome hold stable, and out_valid stays high.
- Stage 1 holds its word while stage 2 is stalled. No word is dropped or duplicated.
- Reset values:
  - out_valid=0, data_out=0, err_corr=0, err_unc=0, syndrome=0, corr_cnt=0, unc_cnt=0.
  - Internal stage valids = 0.
  - in_ready=1 in the first cycle after reset.
- Reset asserted mid-stream discards in-flight words. No handshake completes during the reset cycle.
- Counters update one cycle after the handshake (registered).

## Structure
- Package hamming_12_8_pkg holds:
  - widths DATA_W=8, PAR_W=4, CODE_W=12;
  - the syndrome constants for each data bit (3, 5, 6, 7, 9, 10, 11, 12);
  - function syn2flip(syndrome) returning an 8-bit flip mask.
- Sub-module hamming_syndrome_12_8: combinational, 12-bit codeword in, 4-bit syndrome out. It is reused by later checkers.
- Top level: two pipeline registers, handshake logic and two saturating counters.

## Test plan
- Clean words: code_in 0xA53 (data 0xA5), out_ready=1 → two cycles later data_out=0xA5, syndrome=0, both flags 0, counters unchanged.
- Single errors: 0xAD3 (d3 flipped) → data_out=0xA5, syndrome=7, err_corr=1. 0xA57 (p2 flipped) → data_out=0xA5, syndrome=4, err_corr=1. corr_cnt=2.
- Uncorrectable: 0x252 (d7 and p0 flipped) → syndrome=13, err_unc=1, data_out=0x25, unc_cnt=1.
- Backpressure: stream 10 distinct words while out_ready toggles pseudo-randomly.
  - All 10 delivered in order, none lost or duplicated.
  - Outputs stable while stalled.
  - in_ready=0 only when both stages are full and out_ready=0.
- Counter saturation and clear, with CNT_W=2:
  - 5 corrected words → corr_cnt saturates at 3.
  - cnt_clr coincident with a corrected handshake → corr_cnt=0.
- Reset mid-stream: assert rst with both stages full → next cycle out_valid=0, counters=0, in_ready=1. No stale word emerges afterwards.

Source files
------------

// File: rtl/hamming_12_8_pkg.sv
// Shared constants and decode helpers for the Hamming (12,8) SEC code:
// codeword layout is {d7..d0, p3..p0}.
package hamming_12_8_pkg;

   localparam int DATA_W = 8;
   localparam int PAR_W  = 4;
   localparam int CODE_W = 12;

   // Data bits covered by each parity bit.
   localparam logic [DATA_W-1:0] P0_MASK = 8'h5B;
   localparam logic [DATA_W-1:0] P1_MASK = 8'h6D;
   localparam logic [DATA_W-1:0] P2_MASK = 8'h8E;
   localparam logic [DATA_W-1:0] P3_MASK = 8'hF0;

   localparam logic [PAR_W-1:0] SYN_D0 = 4'd3;
   localparam logic [PAR_W-1:0] SYN_D1 = 4'd5;
   localparam logic [PAR_W-1:0] SYN_D2 = 4'd6;
   localparam logic [PAR_W-1:0] SYN_D3 = 4'd7;
   localparam logic [PAR_W-1:0] SYN_D4 = 4'd9;
   localparam logic [PAR_W-1:0] SYN_D5 = 4'd10;
   localparam logic [PAR_W-1:0] SYN_D6 = 4'd11;
   localparam logic [PAR_W-1:0] SYN_D7 = 4'd12;

   typedef enum logic [1:0] {
      SYN_NONE,
      SYN_PAR,
      SYN_DATA,
      SYN_UNC
   } syn_kind_e;

   function automatic logic [DATA_W-1:0] syn2flip(input logic [PAR_W-1:0] syn);
      logic [DATA_W-1:0] mask;
      mask = '0;
      case (syn)
         SYN_D0:  mask = 8'h01;
         SYN_D1:  mask = 8'h02;
         SYN_D2:  mask = 8'h04;
         SYN_D3:  mask = 8'h08;
         SYN_D4:  mask = 8'h10;
         SYN_D5:  mask = 8'h20;
         SYN_D6:  mask = 8'h40;
         SYN_D7:  mask = 8'h80;
         default: mask = '0;
      endcase
      return mask;
   endfunction

   function automatic syn_kind_e syn_kind(input logic [PAR_W-1:0] syn);
      syn_kind_e kind;
      case (syn)
         4'd0:                kind = SYN_NONE;
         4'd1, 4'd2, 4'd4, 4'd8:  kind = SYN_PAR;
         4'd13, 4'd14, 4'd15: kind = SYN_UNC;
         default:             kind = SYN_DATA;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/hamming_decoder_8bit_stream_if.sv
// Valid/ready codeword input and decoded-result output of the (12,8) decoder.
interface hamming_decoder_8bit_stream_if;
   import hamming_12_8_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] code_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] data_out;
   logic              err_corr;
   logic              err_unc;
   logic [PAR_W-1:0]  syndrome;

   modport slave (
      input  in_valid, code_in, out_ready,
      output in_ready, out_valid, data_out, err_corr, err_unc, syndrome
   );

   modport master (
      output in_valid, code_in, out_ready,
      input  in_ready, out_valid, data_out, err_corr, err_unc, syndrome
   );

endinterface

// File: rtl/hamming_syndrome_12_8.sv
// Combinational syndrome generator: received parity XOR parity recomputed
// from the received data field.
module hamming_syndrome_12_8
   import hamming_12_8_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [PAR_W-1:0]  syndrome
);

   logic [DATA_W-1:0] data;
   logic [PAR_W-1:0]  parity;

   always_comb begin
      data   = code[CODE_W-1:PAR_W];
      parity = {^(data & P3_MASK), ^(data & P2_MASK),
                ^(data & P1_MASK), ^(data & P0_MASK)};
      syndrome = code[PAR_W-1:0] ^ parity;
   end

endmodule

// File: rtl/hamming_decoder_8bit_stream.sv
// Two-stage pipelined Hamming (12,8) decoder with valid/ready flow control
// and saturating corrected/uncorrectable word counters.
module hamming_decoder_8bit_stream
   import hamming_12_8_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   hamming_decoder_8bit_stream_if.slave  stream,
   input  logic                          cnt_clr,
   output logic [CNT_W-1:0]              corr_cnt,
   output logic [CNT_W-1:0]              unc_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              adv1, adv2, in_fire, out_fire;
   logic [PAR_W-1:0]  in_syn;
   syn_kind_e         s1_kind;

   // Stage 1 keeps only the data field; the parity bits live on in the syndrome.
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q,  s1_data_d;
   logic [PAR_W-1:0]  s1_syn_q,   s1_syn_d;

   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q,  s2_data_d;
   logic              s2_corr_q,  s2_corr_d;
   logic              s2_unc_q,   s2_unc_d;
   logic [PAR_W-1:0]  s2_syn_q,   s2_syn_d;

   logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
   logic [CNT_W-1:0]  unc_cnt_q,  unc_cnt_d;

   hamming_syndrome_12_8 u_syn (
      .code     (stream.code_in),
      .syndrome (in_syn)
   );

   // Both handshakes are masked during reset so nothing transfers in that cycle.
   assign adv2             = ~s2_valid_q | stream.out_ready;
   assign adv1             = ~s1_valid_q | adv2;
   assign stream.in_ready  = adv1 & ~rst;
   assign stream.out_valid = s2_valid_q & ~rst;
   assign in_fire          = stream.in_valid & stream.in_ready;
   assign out_fire         = stream.out_valid & stream.out_ready;

   assign stream.data_out  = s2_data_q;
   assign stream.err_corr  = s2_corr_q;
   assign stream.err_unc   = s2_unc_q;
   assign stream.syndrome  = s2_syn_q;
   assign corr_cnt         = corr_cnt_q;
   assign unc_cnt          = unc_cnt_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_syn_d   = s1_syn_q;
      if (adv1) begin
         s1_valid_d = in_fire;
         if (in_fire) begin
            s1_data_d = stream.code_in[CODE_W-1:PAR_W];
            s1_syn_d  = in_syn;
         end
      end
   end

   always_comb begin
      s1_kind    = syn_kind(s1_syn_q);
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_corr_d  = s2_corr_q;
      s2_unc_d   = s2_unc_q;
      s2_syn_d   = s2_syn_q;
      if (adv2) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = s1_data_q ^ syn2flip(s1_syn_q);
            s2_corr_d = (s1_kind == SYN_PAR) || (s1_kind == SYN_DATA);
            s2_unc_d  = (s1_kind == SYN_UNC);
            s2_syn_d  = s1_syn_q;
         end
      end
   end

   // Clear takes priority over a coincident increment.
   always_comb begin
      corr_cnt_d = corr_cnt_q;
      unc_cnt_d  = unc_cnt_q;
      if (cnt_clr) begin
         corr_cnt_d = '0;
         unc_cnt_d  = '0;
      end else if (out_fire) begin
         if (s2_corr_q && corr_cnt_q != CNT_MAX) corr_cnt_d = corr_cnt_q + CNT_W'(1);
         if (s2_unc_q && unc_cnt_q != CNT_MAX)   unc_cnt_d  = unc_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_syn_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_corr_q  <= 1'b0;
         s2_unc_q   <= 1'b0;
         s2_syn_q   <= '0;
         corr_cnt_q <= '0;
         unc_cnt_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_syn_q   <= s1_syn_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_corr_q  <= s2_corr_d;
         s2_unc_q   <= s2_unc_d;
         s2_syn_q   <= s2_syn_d;
         corr_cnt_q <= corr_cnt_d;
         unc_cnt_q  <= unc_cnt_d;
      end
   end

endmodule
